hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Decode-stage pipeline hazard controller; drives the bubble mux that zeroes ID/EX control bits.
//  Detects load-use hazards, taken-branch redirects and data-memory busy, and sequences
//  PC / IF-ID / ID-EX write enables and flushes over one or more cycles.
//  Keeps a saturating stall-cycle counter for performance monitoring.
// PARAMETERS
//  LU_STALLS  1   bubble cycles per load-use hazard (1..7)
//  BR_FLUSH   2   flush cycles after taken branch resolved in EX (1..3)
//  CNT_W      16  width of stall_cnt
// PORTS
//  clk               in   1      clock, all state on rising edge
//  rst_n             in   1      asynchronous, active-low reset
//  id_ex_mem_read    in   1      instruction in EX is a load
//  id_ex_rd          in   5      destination register of EX instruction
//  if_id_rs1         in   5      rs1 of ID instruction
//  if_id_rs2         in   5      rs2 of ID instruction
//  uses_rs1          in   1      ID instruction reads rs1
//  uses_rs2          in   1      ID instruction reads rs2
//  ex_branch_taken   in   1      branch in EX resolved taken (1-cycle pulse)
//  mem_busy          in   1      data memory not ready; whole pipe must freeze
//  pc_write          out  1      PC register write enable
//  if_id_write       out  1      IF/ID register write enable
//  id_ex_write       out  1      ID/EX register write enable
//  control_mux_sel   out  1      1 = bubble mux forces all ID/EX control bits to 0
//  if_id_flush       out  1      1 = IF/ID loaded with NOP
//  stall_cnt         out  CNT_W  saturating count of cycles with pc_write==0 after reset
// BEHAVIOUR
//  States: RUN, LU_STALL, FLUSH, MEM_WAIT. rst_n low -> state RUN, counters 0 immediately.
//  While rst_n low: pc_write=0, if_id_write=0, id_ex_write=0, control_mux_sel=1,
//   if_id_flush=0, stall_cnt=0. Outputs are combinational from state + inputs otherwise.
//  lu_hit = id_ex_mem_read & (id_ex_rd!=0) & ((uses_rs1 & rd==rs1) | (uses_rs2 & rd==rs2)).
//  Priority each cycle: mem_busy > ex_branch_taken > lu_hit > state-held action.
//  RUN, no event: all write enables 1, control_mux_sel=0, if_id_flush=0.
//  mem_busy=1 (any state): pc_write=if_id_write=id_ex_write=0, control_mux_sel=0;
//   next state MEM_WAIT, internal stall/flush counters hold. MEM_WAIT with mem_busy=0
//   returns to the state saved on entry and resumes remaining count.
//  ex_branch_taken (not mem_busy): same cycle pc_write=1, if_id_write=1, if_id_flush=1,
//   control_mux_sel=1; aborts any load-use stall. If BR_FLUSH>1 -> FLUSH for BR_FLUSH-1
//   further cycles with if_id_flush=1, control_mux_sel=1, pc_write=1; then RUN.
//  lu_hit in RUN: same cycle pc_write=0, if_id_write=0, control_mux_sel=1 (1st bubble).
//   If LU_STALLS>1 -> LU_STALL for LU_STALLS-1 more identical cycles, then RUN.
//   lu_hit re-evaluated on return to RUN (back-to-back loads stall again).
//  id_ex_write=1 in every state except MEM_WAIT / mem_busy.
//  stall_cnt += 1 each cycle pc_write==0 (excludes reset); saturates at 2^CNT_W-1, no wrap.
//  Load with id_ex_rd==0 never stalls.
// TESTING
//  lw x5 in EX, ID reads rs1=x5 uses_rs1=1 -> 1 cycle pc_write=0, control_mux_sel=1; stall_cnt=1.
//  Same with rd=x0 -> no stall, control_mux_sel=0, stall_cnt=0.
//  LU_STALLS=3, lu_hit, then ex_branch_taken on 2nd stall cycle -> stall aborted, if_id_flush=1.
//  Taken branch, BR_FLUSH=2 -> if_id_flush=1 for exactly 2 cycles, then RUN with all enables 1.
//  mem_busy high 4 cycles during LU_STALL (LU_STALLS=3, 1 left) -> all enables 0 for 4 cycles,
//   then 1 remaining bubble, then RUN; stall_cnt increments on all 5+ frozen cycles.
//  rst_n low mid-FLUSH -> outputs at reset values asynchronously; release -> RUN next edge.
//  CNT_W=4, 20 stall cycles -> stall_cnt holds 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage hazard controller for an in-order pipeline.
// Sequences load-use bubbles, taken-branch flushes and memory-busy freezes, and counts stall cycles.
module hazard_ctrl #(
   parameter int LU_STALLS = 1,
   parameter int BR_FLUSH  = 2,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_ex_mem_read,
   input  logic [4:0]       id_ex_rd,
   input  logic [4:0]       if_id_rs1,
   input  logic [4:0]       if_id_rs2,
   input  logic             uses_rs1,
   input  logic             uses_rs2,
   input  logic             ex_branch_taken,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_write,
   output logic             control_mux_sel,
   output logic             if_id_flush,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      FLUSH    = 2'd2,
      MEM_WAIT = 2'd3
   } state_t;

   localparam logic [2:0]       LU_LOAD = 3'(LU_STALLS - 1);
   localparam logic [2:0]       BR_LOAD = 3'(BR_FLUSH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_reg, state_next;
   state_t           saved_reg, saved_next;
   state_t           eff_state;
   logic [2:0]       left_reg, left_next;
   logic [CNT_W-1:0] stall_cnt_reg;

   logic [4:0]       src_num [2];
   logic [1:0]       src_used;
   logic [1:0]       src_hit;
   logic             lu_hit;

   assign src_num[0] = if_id_rs1;
   assign src_num[1] = if_id_rs2;
   assign src_used   = {uses_rs2, uses_rs1};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         assign src_hit[gi] = src_used[gi] && (src_num[gi] == id_ex_rd);
      end
   endgenerate

   // x0 is hard-wired zero, so a load targeting it never creates a dependency.
   assign lu_hit = id_ex_mem_read && (id_ex_rd != 5'd0) && (|src_hit);

   always_comb begin
      // Leaving MEM_WAIT acts in the saved state on the same cycle, so no extra bubble is spent.
      eff_state       = (state_reg == MEM_WAIT) ? saved_reg : state_reg;
      state_next      = eff_state;
      saved_next      = saved_reg;
      left_next       = left_reg;
      pc_write        = 1'b1;
      if_id_write     = 1'b1;
      id_ex_write     = 1'b1;
      control_mux_sel = 1'b0;
      if_id_flush     = 1'b0;

      if (mem_busy) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_write = 1'b0;
         state_next  = MEM_WAIT;
         saved_next  = eff_state;
      end else if (ex_branch_taken) begin
         if_id_flush     = 1'b1;
         control_mux_sel = 1'b1;
         if (BR_FLUSH > 1) begin
            state_next = FLUSH;
            left_next  = BR_LOAD;
         end else begin
            state_next = RUN;
            left_next  = 3'd0;
         end
      end else begin
         case (eff_state)
            FLUSH: begin
               if_id_flush     = 1'b1;
               control_mux_sel = 1'b1;
               if (left_reg <= 3'd1) begin
                  state_next = RUN;
                  left_next  = 3'd0;
               end else begin
                  left_next  = left_reg - 3'd1;
               end
            end
            LU_STALL: begin
               pc_write        = 1'b0;
               if_id_write     = 1'b0;
               control_mux_sel = 1'b1;
               if (left_reg <= 3'd1) begin
                  state_next = RUN;
                  left_next  = 3'd0;
               end else begin
                  left_next  = left_reg - 3'd1;
               end
            end
            default: begin
               if (lu_hit) begin
                  pc_write        = 1'b0;
                  if_id_write     = 1'b0;
                  control_mux_sel = 1'b1;
                  if (LU_STALLS > 1) begin
                     state_next = LU_STALL;
                     left_next  = LU_LOAD;
                  end
               end
            end
         endcase
      end

      if (!rst_n) begin
         pc_write        = 1'b0;
         if_id_write     = 1'b0;
         id_ex_write     = 1'b0;
         control_mux_sel = 1'b1;
         if_id_flush     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= RUN;
         saved_reg     <= RUN;
         left_reg      <= 3'd0;
         stall_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         saved_reg <= saved_next;
         left_reg  <= left_next;
         if (!pc_write && (stall_cnt_reg != CNT_MAX)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
         end
      end
   end

   assign stall_cnt = stall_cnt_reg;

endmodule
